// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, branch, MDU and dmem-wait hazards.
// Optional perf counters are built when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_op,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             mdu_start,
  output logic             mdu_err,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam int unsigned TO_W = $clog2(MDU_TIMEOUT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic freeze;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic to_hit;

  assign freeze   = mem_req & ~mem_ready;
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_memread & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  assign to_hit   = (to_cnt_q == TO_W'(MDU_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // A frozen cycle holds both state and timeout count.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    if (!freeze) begin
      unique case (state_q)
        RUN: begin
          if (!ex_branch_taken && ex_mdu_op) begin
            state_d  = MDU_BUSY;
            to_cnt_d = '0;
          end
        end
        MDU_BUSY: begin
          if (mdu_done || to_hit) begin
            state_d  = RUN;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        default: begin
          state_d  = RUN;
          to_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_we      = 1'b1;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    mdu_start    = 1'b0;
    mdu_err      = 1'b0;
    if (reset) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
    end else if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mdu_op) begin
            mdu_start    = 1'b1;
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MDU_BUSY: begin
          if (mdu_done) begin
            mdu_err = 1'b0;
          end else if (to_hit) begin
            mdu_err = 1'b1;
          end else begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
          end
        end
        default: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_we = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((ifid_flush || idex_flush) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: constant vector table, hand-written MDU/freeze/reset sequences,
// and randomized cycles checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CW      = 32;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble, mdu_start, mdu_err}
  localparam logic [7:0] V_DEF   = 8'b1101_0000;
  localparam logic [7:0] V_LU    = 8'b0001_1000;
  localparam logic [7:0] V_BR    = 8'b1111_1000;
  localparam logic [7:0] V_START = 8'b0000_0110;
  localparam logic [7:0] V_BUSY  = 8'b0000_0100;
  localparam logic [7:0] V_ERR   = 8'b1101_0001;
  localparam logic [7:0] V_FRZ   = 8'b0000_0000;
  localparam logic [7:0] V_RST   = 8'b0010_1100;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_memread;
  logic          ex_branch_taken, ex_mdu_op, mdu_done, mem_req, mem_ready;
  logic          pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble, mdu_start, mdu_err;
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;
  logic [7:0]    act;

  int checks = 0;
  int errors = 0;

  // Reference model state: busy flag, count of counted stall cycles, perf totals.
  bit     m_busy;
  int     m_waited;
  longint m_stalls;
  longint m_flushes;
  logic [7:0] m_exp;

  pipe_hazard_ctrl #(.MDU_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_op(ex_mdu_op), .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_bubble(exmem_bubble), .mdu_start(mdu_start),
    .mdu_err(mdu_err), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  assign act = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble, mdu_start, mdu_err};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(ex_branch_taken && ex_mdu_op))
      else $error("illegal stimulus: branch and MDU op together");
  end

  function automatic logic [7:0] model_out();
    bit frz, hazard;
    frz    = mem_req && !mem_ready;
    hazard = ex_memread && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (reset)                           return V_RST;
    if (frz)                             return V_FRZ;
    if (m_busy) begin
      if (mdu_done)                      return V_DEF;
      if (m_waited == int'(TIMEOUT))     return V_ERR;
      return V_BUSY;
    end
    if (ex_branch_taken)                 return V_BR;
    if (ex_mdu_op)                       return V_START;
    if (hazard)                          return V_LU;
    return V_DEF;
  endfunction

  task automatic model_advance();
    longint sat;
    sat = (longint'(1) << CW) - 1;
    if (reset) begin
      m_busy = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    if (m_exp[7] == 1'b0) m_stalls  = (m_stalls  < sat) ? m_stalls  + 1 : sat;
    if (m_exp[5] || m_exp[3]) m_flushes = (m_flushes < sat) ? m_flushes + 1 : sat;
    if (mem_req && !mem_ready) return;
    if (!m_busy) begin
      if (!ex_branch_taken && ex_mdu_op) begin m_busy = 1; m_waited = 0; end
    end else if (mdu_done || m_waited == int'(TIMEOUT)) begin
      m_busy = 0; m_waited = 0;
    end else begin
      m_waited++;
    end
  endtask

  task automatic check_vec(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: outputs got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] got, input longint want);
    checks++;
    if (got !== CW'(want)) begin
      errors++;
      $display("FAIL %s: counter got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // One cycle: model check, optional explicit constant check, then advance at the edge.
  task automatic step(input string name, input bit use_exp, input logic [7:0] exp);
    @(negedge clk);
    m_exp = model_out();
    check_vec({name, "/model"}, act, m_exp);
    if (use_exp) check_vec(name, act, exp);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check_cnt({name, "/stall_cnt"}, perf_stall_cnt, m_stalls);
    check_cnt({name, "/flush_cnt"}, perf_flush_cnt, m_flushes);
`else
    check_cnt({name, "/stall_cnt"}, perf_stall_cnt, 0);
    check_cnt({name, "/flush_cnt"}, perf_flush_cnt, 0);
`endif
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_memread = 0; ex_rd = 0; ex_branch_taken = 0; ex_mdu_op = 0;
    mdu_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, memread, br, done, mreq, mrdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"lu_rs1",       5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, 0, V_LU});
    vecs.push_back('{"lu_rd0",       5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 0, V_DEF});
    vecs.push_back('{"lu_rs2",       5'd1, 5'd9, 5'd9, 1, 1, 1, 0, 0, 0, 0, V_LU});
    vecs.push_back('{"lu_unused",    5'd7, 5'd7, 5'd7, 0, 0, 1, 0, 0, 0, 0, V_DEF});
    vecs.push_back('{"lu_noload",    5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, V_DEF});
    vecs.push_back('{"lu_nomatch",   5'd4, 5'd6, 5'd5, 1, 1, 1, 0, 0, 0, 0, V_DEF});
    vecs.push_back('{"br_over_lu",   5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, 0, V_BR});
    vecs.push_back('{"br_alone",     5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, V_BR});
    vecs.push_back('{"frz_lu",       5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 1, 0, V_FRZ});
    vecs.push_back('{"frz_br",       5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, 0, V_FRZ});
    vecs.push_back('{"memrdy_lu",    5'd3, 5'd3, 5'd3, 0, 1, 1, 0, 0, 1, 1, V_LU});
    vecs.push_back('{"done_in_run",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, V_DEF});

    m_busy = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    idle();
    reset = 1;
    #1;
    step("reset0", 1, V_RST);
    step("reset1", 1, V_RST);
    reset = 0;
    step("post_reset", 1, V_DEF);

    foreach (vecs[i]) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; ex_memread = vecs[i].memread;
      ex_branch_taken = vecs[i].br; mdu_done = vecs[i].done;
      mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      step(vecs[i].name, 1, vecs[i].exp);
    end
    idle();

    // MDU normal: start + 4 busy stalls, done on the 5th cycle after launch.
    ex_mdu_op = 1;
    step("mdu_start", 1, V_START);
    for (int i = 0; i < 4; i++) step("mdu_busy", 1, V_BUSY);
    mdu_done = 1;
    step("mdu_done", 1, V_DEF);
    idle();
    step("mdu_back_run", 1, V_DEF);

    // MDU timeout: 8 counted busy cycles, then a single error cycle.
    ex_mdu_op = 1;
    step("to_start", 1, V_START);
    for (int i = 0; i < int'(TIMEOUT); i++) step("to_busy", 1, V_BUSY);
    step("to_err", 1, V_ERR);
    idle();
    step("to_resume", 1, V_DEF);

    // Freeze inside MDU_BUSY must not advance the timeout count.
    ex_mdu_op = 1;
    step("fz_start", 1, V_START);
    step("fz_busy_a", 1, V_BUSY);
    step("fz_busy_b", 1, V_BUSY);
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step("fz_frozen", 1, V_FRZ);
    mem_req = 0;
    for (int i = 0; i < int'(TIMEOUT) - 2; i++) step("fz_busy_c", 1, V_BUSY);
    step("fz_err", 1, V_ERR);
    idle();
    step("fz_resume", 1, V_DEF);

    // Reset in the middle of MDU_BUSY.
    ex_mdu_op = 1;
    step("rm_start", 1, V_START);
    step("rm_busy", 1, V_BUSY);
    step("rm_busy2", 1, V_BUSY);
    reset = 1;
    step("rm_reset", 1, V_RST);
    reset = 0; ex_mdu_op = 0;
    step("rm_run", 1, V_DEF);
    check_cnt("rm_stall_zero", perf_stall_cnt, 0);
    check_cnt("rm_flush_zero", perf_flush_cnt, 0);

    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_mdu_op = !ex_branch_taken && ($urandom_range(0, 9) == 0);
      mdu_done = ($urandom_range(0, 5) == 0);
      mem_req = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      step("random", 0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Generates per-stage write enables and bubble/flush controls from four hazard sources:
  - load-use hazard
  - taken branch in EX
  - multi-cycle MUL/DIV unit (MDU) in EX
  - data-memory wait in MEM
- Sits beside the pipeline registers and owns all pipeline-register control signals.

Parameters:
- MDU_TIMEOUT, 64, max cycles in MDU_BUSY (non-frozen) before a forced release.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  source register 1 of instruction in ID
- id_rs2  in  5  source register 2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_memread  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_mdu_op  in  1  EX instruction is a MUL/DIV
- mdu_done  in  1  MDU result valid (meaningful only in MDU_BUSY)
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_we  out  1  PC register update enable
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_we  out  1  ID/EX register write enable
- idex_flush  out  1  load bubble into ID/EX
- exmem_bubble  out  1  load bubble into EX/MEM
- mdu_start  out  1  single-cycle MDU launch pulse
- mdu_err  out  1  single-cycle MDU timeout pulse
- perf_stall_cnt  out  CNT_W  stall cycle count
- perf_flush_cnt  out  CNT_W  flush event count

Behaviour:
- States: RUN, MDU_BUSY. Reset state is RUN. Outputs are combinational from state and inputs.
- While reset is high:
  - pc_we=0, ifid_we=0, idex_we=0
  - ifid_flush=1, idex_flush=1, exmem_bubble=1
  - mdu_start=0, mdu_err=0
  - timeout counter=0, perf counters=0
- Defaults (no hazard): pc_we=ifid_we=idex_we=1; all flush/bubble/pulse outputs 0.
- freeze = mem_req & ~mem_ready. freeze has highest priority in any state:
  - all *_we=0, all flush/bubble=0, mdu_start=0
  - state held, timeout counter paused
  - ex_branch_taken and the load-use check are ignored and re-evaluated after release.
- RUN, in priority order after freeze:
  1. ex_branch_taken: pc_we=1 (redirect), ifid_flush=1, idex_flush=1. Load-use is suppressed.
  2. ex_mdu_op: mdu_start=1, pc_we=ifid_we=idex_we=0, exmem_bubble=1; next state MDU_BUSY.
  3. Load-use, defined as ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)):
     - pc_we=0, ifid_we=0, idex_flush=1
     - exactly one bubble per hazard, because the bubble clears ex_memread.
- ex_branch_taken and ex_mdu_op asserted together is illegal; the bench asserts it never happens.
- MDU_BUSY, while not done and not timed out:
  - pc_we=ifid_we=idex_we=0, exmem_bubble=1
  - timeout counter increments each non-frozen cycle.
- MDU_BUSY exits to RUN on either event, and the counter clears:
  - mdu_done: default enables this cycle (EX advances).
  - Counter reaches MDU_TIMEOUT without mdu_done: mdu_err=1 for one cycle, default enables this cycle.
- mdu_done while in RUN is ignored. mdu_start is never re-issued for the same instruction.
- Timeout counter width is $clog2(MDU_TIMEOUT+1).
- Reset asserted mid-MDU_BUSY: next state RUN, counter 0, no mdu_err.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- With the macro defined:
  - perf_stall_cnt increments in every non-reset cycle with pc_we=0.
  - perf_flush_cnt increments in every non-reset cycle with ifid_flush|idex_flush=1.
  - Both counters saturate at all-ones.
- Without the macro: both outputs are constant 0 and no counter flops are generated.

Test Plan:
- Load-use hazard:
  - Stimulus: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1.
  - Response: one cycle of pc_we=0, ifid_we=0, idex_flush=1.
  - Repeat with ex_rd=0: response is no stall.
- Branch vs load-use:
  - Stimulus: ex_branch_taken=1 together with load-use condition.
  - Response: pc_we=1, ifid_flush=1, idex_flush=1; no stall.
- MDU normal:
  - Stimulus: ex_mdu_op=1; mdu_done raised 5 cycles later.
  - Response: mdu_start pulses once; pc_we=0 for 5 cycles; enables return to 1 in the done cycle; state returns to RUN.
- MDU timeout:
  - Stimulus: MDU_TIMEOUT=8, mdu_done never asserted.
  - Response: mdu_err pulses once after 8 MDU_BUSY cycles; pipe resumes.
- Freeze:
  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles during MDU_BUSY, with mdu_done delayed.
  - Response: all enables and bubbles 0 for those 3 cycles; timeout count unchanged.
- Reset mid-MDU:
  - Stimulus: reset asserted during MDU_BUSY.
  - Response: next cycle state RUN, mdu_err=0, reset output values as listed above.
  - With PIPE_HAZARD_PERF_CNT_EN: counters read 0 after reset.
